slice_adder_seq: RTL and testbench
==================================

SLICE_ADDER_SEQ -- requirements
Module: slice_adder_seq

Interface
REQ-001 The module SHALL have parameter NSLICE, default 4, giving the number of 5-bit slices per operand.
REQ-002 The module SHALL derive W = 5*NSLICE, default 20, as the operand and sum width; NSLICE SHALL be at least 2.
REQ-003 Port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-004 Port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 Port in_valid, input, 1 bit: the operand set on in_a, in_b and in_ci is valid.
REQ-006 Port in_ready, output, 1 bit: the block can accept an operand set this cycle.
REQ-007 Port in_a, input, W bits: operand A.
REQ-008 Port in_b, input, W bits: operand B.
REQ-009 Port in_ci, input, 1 bit: carry-in to slice 0.
REQ-010 Port out_valid, output, 1 bit: the result on out_sum and out_co is valid.
REQ-011 Port out_ready, input, 1 bit: the consumer accepts the result.
REQ-012 Port out_sum, output, W bits: the sum, (in_a + in_b + in_ci) mod 2^W.
REQ-013 Port out_co, output, 1 bit: carry-out of bit W-1.
REQ-014 Port busy, output, 1 bit: high whenever the state is not IDLE.

Function
REQ-015 The block SHALL instantiate exactly one 5-bit carry-lookahead adder slice (adder_5bits: a, b, ci, s, co) and SHALL time-share it across all NSLICE slices; there SHALL be no other adder of 5 bits or wider.
REQ-016 The block SHALL implement a state machine with three states: IDLE, RUN and DONE.
REQ-017 A transfer on the input side SHALL occur on any rising edge with in_valid=1 and in_ready=1.
REQ-018 in_ready SHALL equal (state==IDLE) or (state==DONE and out_ready==1), as a combinational output.
REQ-019 On an input transfer the block SHALL register in_a, in_b and in_ci, set slice index idx to 0, load the carry register with in_ci and enter RUN.
REQ-020 In RUN, the adder inputs SHALL be a = A[5*idx +: 5], b = B[5*idx +: 5] and ci = the carry register.
REQ-021 In RUN, each edge SHALL write the adder s output into sum register bits [5*idx +: 5] and load the adder co output into the carry register.
REQ-022 In RUN, when idx < NSLICE-1 the block SHALL increment idx and remain in RUN.
REQ-023 In RUN, when idx == NSLICE-1 the block SHALL load out_co from the adder co output and enter DONE; idx SHALL never wrap past NSLICE-1.
REQ-024 The block SHALL spend exactly NSLICE cycles in RUN per operation.
REQ-025 out_valid SHALL be high exactly when the state is DONE; it SHALL first rise NSLICE edges after the input transfer edge.
REQ-026 In DONE with out_ready=0, the block SHALL hold out_sum, out_co and out_valid stable, and in_ready SHALL be 0.
REQ-027 In DONE with out_ready=1 and in_valid=0, the block SHALL enter IDLE.
REQ-028 In DONE with out_ready=1 and in_valid=1, the output transfer and a new input capture SHALL occur on the same edge and the block SHALL go directly to RUN; sustained throughput is one result per NSLICE+1 cycles.
REQ-029 in_valid in RUN SHALL be ignored (in_ready=0) and SHALL NOT disturb the operation in progress.
REQ-030 out_sum and out_co SHALL be driven from registers; the sum register bits from a completed operation SHALL remain visible until overwritten slice by slice by the next operation.

Reset
REQ-031 While rst_n=0 the block SHALL force state=IDLE, idx=0, carry=0, out_sum=0, out_co=0, out_valid=0 and busy=0; in_ready SHALL therefore be 1.
REQ-032 Reset asserted during RUN or DONE SHALL abort the operation with no result presented; the first edge after rst_n rises MAY accept new input.

Verification
REQ-033 With NSLICE=4: in_a=0xFFFFF, in_b=0x00001, in_ci=0, accepted at edge T -> out_valid=1 after edge T+4, out_sum=0x00000, out_co=1.
REQ-034 in_a=0x12345, in_b=0x0ABCD, in_ci=1 -> out_sum=0x1CF13, out_co=0; additionally in_a=0, in_b=0, in_ci=1 -> out_sum=0x00001, out_co=0.
REQ-035 Result present with out_ready held 0 for 3 cycles while in_valid=1 -> out_sum, out_co and out_valid stable, in_ready=0, no capture; out_ready then 1 -> same-edge capture, busy stays 1.
REQ-036 Back-to-back stream of 8 random operand sets with out_ready=1 -> every result matches a reference sum, and consecutive results are spaced exactly 5 cycles apart.
REQ-037 rst_n driven 0 at RUN idx=2 -> out_valid=0, out_sum=0, in_ready=1 immediately; after release, a new operation completes correctly with no carry leaked from the aborted one.

Source files
------------

// File: rtl/slice_adder_seq.sv
// W-bit adder that time-shares one 5-bit CLA slice over NSLICE cycles; result NSLICE edges after capture.
// Valid/ready on both sides; a held result blocks new input unless it is consumed on the same edge.
module adder_5bits (
  input  logic [4:0] a,
  input  logic [4:0] b,
  input  logic       ci,
  output logic [4:0] s,
  output logic       co
);
  logic [4:0] g;
  logic [4:0] p;
  logic [5:0] c;

  assign g = a & b;
  assign p = a ^ b;

  // Every carry is a flat sum of generate/propagate products, no carry chaining.
  assign c[0] = ci;
  assign c[1] = g[0] | (p[0] & ci);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
  assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & ci);
  assign c[5] = g[4] | (p[4] & g[3]) | (p[4] & p[3] & g[2]) | (p[4] & p[3] & p[2] & g[1])
              | (p[4] & p[3] & p[2] & p[1] & g[0]) | (p[4] & p[3] & p[2] & p[1] & p[0] & ci);

  assign s  = p ^ c[4:0];
  assign co = c[5];
endmodule

module slice_adder_seq #(
  parameter  int NSLICE = 4,
  localparam int W      = 5 * NSLICE
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_a,
  input  logic [W-1:0] in_b,
  input  logic         in_ci,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_sum,
  output logic         out_co,
  output logic         busy
);
  localparam int IW = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NSLICE - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]    state;
  logic [IW-1:0] idx;
  logic          carry_q;
  logic [W-1:0]  a_q;
  logic [W-1:0]  b_q;
  logic [W-1:0]  sum_q;
  logic          co_q;
  logic          in_fire;
  logic [4:0]    add_s;
  logic          add_co;

  assign in_ready  = (state == ST_IDLE) || ((state == ST_DONE) && out_ready);
  assign in_fire   = in_valid && in_ready;
  assign out_valid = (state == ST_DONE);
  assign busy      = (state != ST_IDLE);
  assign out_sum   = sum_q;
  assign out_co    = co_q;

  adder_5bits u_slice (
    .a  (a_q[5*idx +: 5]),
    .b  (b_q[5*idx +: 5]),
    .ci (carry_q),
    .s  (add_s),
    .co (add_co)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      idx     <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      co_q    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (in_fire) begin
            a_q     <= in_a;
            b_q     <= in_b;
            carry_q <= in_ci;
            idx     <= '0;
            state   <= ST_RUN;
          end else if (state == ST_DONE && out_ready) begin
            state <= ST_IDLE;
          end
        end
        ST_RUN: begin
          // sum_q is overwritten one slice at a time; upper slices keep the previous result until reached.
          sum_q[5*idx +: 5] <= add_s;
          carry_q           <= add_co;
          if (idx == LAST_IDX) begin
            co_q  <= add_co;
            state <= ST_DONE;
          end else begin
            idx <= idx + IW'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_slice_adder_seq.sv
// Bench for slice_adder_seq: vector table, stall, back-to-back stream and reset-abort sequences.
module tb_slice_adder_seq;
  localparam int NSLICE = 4;
  localparam int W      = 5 * NSLICE;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic         in_ci;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_sum;
  logic         out_co;
  logic         busy;

  slice_adder_seq #(.NSLICE(NSLICE)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_ci     (in_ci),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_co    (out_co),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         ci;
    logic [W-1:0] sum;
    logic         co;
  } vec_t;

  typedef struct {
    logic [W-1:0] sum;
    logic         co;
  } exp_t;

  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  bit   rec_times = 1'b0;
  exp_t sb_q[$];
  int   out_times[$];
  exp_t mon_e;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic timeout_fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out waiting (cycle %0d)", name, cyc);
  endtask

  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci);
    logic [W:0] t;
    exp_t e;
    t = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, ci};
    e.sum = t[W-1:0];
    e.co  = t[W];
    return e;
  endfunction

  // Scoreboard consumer: every output transfer pops and compares one expectation.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result: got sum 0x%0h with nothing expected", out_sum);
      end else begin
        mon_e = sb_q.pop_front();
        check("out_sum", out_sum, mon_e.sum);
        check("out_co", out_co, mon_e.co);
      end
      if (rec_times) out_times.push_back(cyc);
    end
  end

  // Drive one operand set, push its expectation on acceptance, return the transfer cycle.
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci,
                      input logic [W-1:0] es, input logic eco, output int tcyc);
    int   n;
    exp_t e;
    in_a = a; in_b = b; in_ci = ci; in_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    tcyc = cyc;
    if (!in_ready) begin
      timeout_fail("in_ready_wait");
      in_valid = 1'b0;
    end else begin
      e.sum = es; e.co = eco;
      sb_q.push_back(e);
      @(posedge clk);
      #1;
      tcyc = cyc;
      in_valid = 1'b0;
    end
  endtask

  task automatic wait_out(input int tcyc, input bit chk_lat);
    int n;
    n = 0;
    @(negedge clk);
    while (!out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!out_valid) timeout_fail("out_valid_wait");
    else if (chk_lat) check("latency", cyc - tcyc, NSLICE);
    @(posedge clk);
    #1;
  endtask

  vec_t vecs[6];
  exp_t e;
  int   tc;
  int   n;
  logic [31:0] r;

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{a: 20'hFFFFF, b: 20'h00001, ci: 1'b0, sum: 20'h00000, co: 1'b1};
    vecs[1] = '{a: 20'h12345, b: 20'h0ABCD, ci: 1'b1, sum: 20'h1CF13, co: 1'b0};
    vecs[2] = '{a: 20'h00000, b: 20'h00000, ci: 1'b1, sum: 20'h00001, co: 1'b0};
    vecs[3] = '{a: 20'hFFFFF, b: 20'hFFFFF, ci: 1'b1, sum: 20'hFFFFF, co: 1'b1};
    vecs[4] = '{a: 20'h0001F, b: 20'h00001, ci: 1'b0, sum: 20'h00020, co: 1'b0};
    vecs[5] = '{a: 20'h80000, b: 20'h80000, ci: 1'b0, sum: 20'h00000, co: 1'b1};

    rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_ci = 1'b0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_sum", out_sum, 0);
    check("rst_out_co", out_co, 0);
    check("rst_busy", busy, 0);
    check("rst_in_ready", in_ready, 1);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Vector table, consumer always ready.
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      send(vecs[i].a, vecs[i].b, vecs[i].ci, vecs[i].sum, vecs[i].co, tc);
      wait_out(tc, 1'b1);
    end

    // Stall with a pending input, then same-edge output transfer and capture.
    out_ready = 1'b0;
    send(20'h12345, 20'h0ABCD, 1'b1, 20'h1CF13, 1'b0, tc);
    wait_out(tc, 1'b1);
    in_a = 20'h54321; in_b = 20'h0F0F0; in_ci = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stall_in_ready", in_ready, 0);
      check("stall_out_valid", out_valid, 1);
      check("stall_out_sum", out_sum, 20'h1CF13);
      check("stall_out_co", out_co, 0);
      check("stall_busy", busy, 1);
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    @(negedge clk);
    check("release_in_ready", in_ready, 1);
    sb_q.push_back(model(20'h54321, 20'h0F0F0, 1'b0));
    @(posedge clk);
    #1 in_valid = 1'b0;
    tc = cyc;
    check("sameedge_busy", busy, 1);
    check("sameedge_out_valid", out_valid, 0);
    wait_out(tc, 1'b1);

    // Back-to-back random stream.
    out_times.delete();
    rec_times = 1'b1;
    in_valid = 1'b1;
    for (int k = 0; k < 8; k++) begin
      r = $urandom; in_a = r[W-1:0];
      r = $urandom; in_b = r[W-1:0];
      r = $urandom; in_ci = r[0];
      n = 0;
      @(negedge clk);
      while (!in_ready && n < 50) begin
        @(negedge clk);
        n++;
      end
      if (!in_ready) timeout_fail("stream_ready_wait");
      else sb_q.push_back(model(in_a, in_b, in_ci));
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    n = 0;
    while (sb_q.size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    if (sb_q.size() != 0) timeout_fail("stream_drain");
    #1 rec_times = 1'b0;
    check("stream_count", out_times.size(), 8);
    for (int k = 1; k < out_times.size(); k++)
      check("stream_spacing", out_times[k] - out_times[k-1], NSLICE + 1);

    // Reset mid-operation at idx 2, with a live carry and partial sum.
    send(20'hFFC21, 20'h003FF, 1'b0, 20'h00000, 1'b0, tc);
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("abort_out_valid", out_valid, 0);
    check("abort_out_sum", out_sum, 0);
    check("abort_out_co", out_co, 0);
    check("abort_in_ready", in_ready, 1);
    check("abort_busy", busy, 0);
    sb_q.delete();
    @(posedge clk);
    #1 rst_n = 1'b1;
    send(20'h00000, 20'h00000, 1'b0, 20'h00000, 1'b0, tc);
    wait_out(tc, 1'b1);
    e = model(20'h0ACE1, 20'h13579, 1'b0);
    send(20'h0ACE1, 20'h13579, 1'b0, e.sum, e.co, tc);
    wait_out(tc, 1'b1);

    repeat (2) @(posedge clk);
    check("sb_empty", sb_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
